tdm_demux4: RTL and testbench

//   Receive end of the 4:1 multiplexed link: takes one time-multiplexed data

---
 rtl/tdm_pkg.sv | 23 ++
 rtl/demux1_4.sv | 24 ++
 rtl/tdm_demux4.sv | 113 +++++++++++
 tb/tb_tdm_demux4.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive path.
// Slot numbering and lock-state encoding.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic logic [1:0] next_slot(
    input logic [1:0] slot
  );
    return slot + 2'd1;
  endfunction

endpackage

// File: rtl/demux1_4.sv
// Slot decoder: binary slot plus capture enable
// to one-hot channel write enables.
module demux1_4
  import tdm_pkg::*;
(
  input  logic       en_cap,
  input  logic [1:0] slot,
  output logic [3:0] we
);

  always_comb begin
    we = 4'b0000;
    if (en_cap) begin
      unique case (1'b1)
        (slot == SLOT_A): we = 4'b0001;
        (slot == SLOT_B): we = 4'b0010;
        (slot == SLOT_C): we = 4'b0100;
        (slot == SLOT_D): we = 4'b1000;
        default:          we = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 1:4 TDM demultiplexer with
// frame-sync lock and realignment.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter bit LATCH_FRAME = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [1:0]       s,
  output logic [3:0]       valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  state_t           state;
  logic [1:0]       s_q;
  logic             cap;
  logic             realign;
  logic             last;
  logic [1:0]       slot;
  logic [3:0]       we;
  logic [WIDTH-1:0] ch_q [NUM_SLOTS];

  // A sync always forces slot 0, in HUNT and LOCK alike.
  assign cap     = en & ((state == ST_LOCK) | sync);
  assign slot    = sync ? SLOT_A : s_q;
  assign realign = en & sync
                 & (state == ST_LOCK)
                 & (s_q != SLOT_A);
  assign last    = cap & (slot == SLOT_D);

  demux1_4 u_dec (
    .en_cap (cap),
    .slot   (slot),
    .we     (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      s_q        <= SLOT_A;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= last;
      sync_err   <= realign;
      if (cap) begin
        s_q <= next_slot(slot);
        if (state == ST_HUNT) begin
          state  <= ST_LOCK;
          locked <= 1'b1;
        end
      end
    end
  end

  generate
    if (LATCH_FRAME) begin : g_latch
      logic [WIDTH-1:0] shadow [NUM_SLOTS-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_SLOTS - 1; i++)
            shadow[i] <= '0;
          for (int i = 0; i < NUM_SLOTS; i++)
            ch_q[i] <= '0;
          valid <= 4'b0000;
        end else begin
          for (int i = 0; i < NUM_SLOTS - 1; i++)
            if (we[i]) shadow[i] <= din;
          // Slot d bypasses its shadow so the
          // whole frame lands on one edge.
          if (last) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++)
              ch_q[i] <= shadow[i];
            ch_q[NUM_SLOTS-1] <= din;
          end
          valid <= {4{last}};
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_SLOTS; i++)
            ch_q[i] <= '0;
          valid <= 4'b0000;
        end else begin
          for (int i = 0; i < NUM_SLOTS; i++)
            if (we[i]) ch_q[i] <= din;
          valid <= we;
        end
      end
    end
  endgenerate

  assign s     = s_q;
  assign out_a = ch_q[0];
  assign out_b = ch_q[1];
  assign out_c = ch_q[2];
  assign out_d = ch_q[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed
// table, latched-frame sequences, random vs model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din1;

  logic [3:0] o0 [4];
  logic [1:0] s0;
  logic [3:0] v0;
  logic       fd0, lk0, er0;

  logic [3:0] o1 [4];
  logic [1:0] s1;
  logic [3:0] v1;
  logic       fd1, lk1, er1;

  logic       o2 [4];
  logic [1:0] s2;
  logic [3:0] v2;
  logic       fd2, lk2, er2;

  int total = 0;
  int bad = 0;

  assign din1 = din[0];

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(4), .LATCH_FRAME(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .din(din),
    .out_a(o0[0]), .out_b(o0[1]),
    .out_c(o0[2]), .out_d(o0[3]),
    .s(s0), .valid(v0), .frame_done(fd0),
    .locked(lk0), .sync_err(er0)
  );

  tdm_demux4 #(.WIDTH(4), .LATCH_FRAME(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .din(din),
    .out_a(o1[0]), .out_b(o1[1]),
    .out_c(o1[2]), .out_d(o1[3]),
    .s(s1), .valid(v1), .frame_done(fd1),
    .locked(lk1), .sync_err(er1)
  );

  tdm_demux4 #(.WIDTH(1), .LATCH_FRAME(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .din(din1),
    .out_a(o2[0]), .out_b(o2[1]),
    .out_c(o2[2]), .out_d(o2[3]),
    .s(s2), .valid(v2), .frame_done(fd2),
    .locked(lk2), .sync_err(er2)
  );

  // Reference model: channel arrays indexed by slot.
  bit         m_lock;
  int         m_s;
  logic [3:0] m_o0 [4];
  logic [3:0] m_o1 [4];
  logic [3:0] m_sh [4];
  logic [3:0] m_v0, m_v1;
  bit         m_fd, m_err;

  function automatic void m_reset();
    m_lock = 0;
    m_s = 0;
    m_v0 = 4'h0;
    m_v1 = 4'h0;
    m_fd = 0;
    m_err = 0;
    for (int i = 0; i < 4; i++) begin
      m_o0[i] = 4'h0;
      m_o1[i] = 4'h0;
      m_sh[i] = 4'h0;
    end
  endfunction

  function automatic void m_step(
    input logic e, input logic sy, input logic [3:0] d
  );
    bit cap = 0;
    int k = 0;
    m_v0 = 4'h0;
    m_v1 = 4'h0;
    m_fd = 0;
    m_err = 0;
    if (e) begin
      if (sy) begin
        if (m_lock && m_s != 0) m_err = 1;
        m_lock = 1;
        k = 0;
        cap = 1;
      end else if (m_lock) begin
        k = m_s;
        cap = 1;
      end
    end
    if (cap) begin
      m_o0[k] = d;
      m_sh[k] = d;
      m_v0 = 4'(1 << k);
      if (k == 3) begin
        m_fd = 1;
        for (int i = 0; i < 4; i++) m_o1[i] = m_sh[i];
        m_v1 = 4'hF;
      end
      m_s = (k + 1) % 4;
    end
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "/d0.out"}, 32'(o0[i]), 32'(m_o0[i]));
      chk({tag, "/d1.out"}, 32'(o1[i]), 32'(m_o1[i]));
      chk({tag, "/d2.out"}, 32'(o2[i]),
          32'(m_o0[i][0]));
    end
    chk({tag, "/d0.v"}, 32'(v0), 32'(m_v0));
    chk({tag, "/d1.v"}, 32'(v1), 32'(m_v1));
    chk({tag, "/d2.v"}, 32'(v2), 32'(m_v0));
    chk({tag, "/d0.s"}, 32'(s0), 32'(m_s));
    chk({tag, "/d1.s"}, 32'(s1), 32'(m_s));
    chk({tag, "/d2.s"}, 32'(s2), 32'(m_s));
    chk({tag, "/d0.fd"}, 32'(fd0), 32'(m_fd));
    chk({tag, "/d1.fd"}, 32'(fd1), 32'(m_fd));
    chk({tag, "/d2.fd"}, 32'(fd2), 32'(m_fd));
    chk({tag, "/d0.lk"}, 32'(lk0), 32'(m_lock));
    chk({tag, "/d1.lk"}, 32'(lk1), 32'(m_lock));
    chk({tag, "/d2.lk"}, 32'(lk2), 32'(m_lock));
    chk({tag, "/d0.err"}, 32'(er0), 32'(m_err));
    chk({tag, "/d1.err"}, 32'(er1), 32'(m_err));
    chk({tag, "/d2.err"}, 32'(er2), 32'(m_err));
  endtask

  task automatic tick(
    input logic e, input logic sy,
    input logic [3:0] d, input string tag
  );
    @(negedge clk);
    en = e;
    sync = sy;
    din = d;
    @(posedge clk);
    #1;
    m_step(e, sy, d);
    check_all(tag);
  endtask

  // Async assert mid-cycle, release on a negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all(tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'($urandom);
      sync = 1'($urandom);
      din = 4'($urandom);
      @(posedge clk);
      #1;
      check_all(tag);
    end
    @(negedge clk);
    en = 1'b0;
    sync = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic        sync;
    logic [3:0]  din;
    logic [15:0] outs;
    logic [3:0]  v;
    logic [1:0]  s;
    logic        fd;
    logic        err;
    logic        lk;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(
    input logic e, input logic sy, input logic [3:0] d,
    input logic [15:0] o, input logic [3:0] v,
    input logic [1:0] s, input logic fd,
    input logic er, input logic lk
  );
    vec_t r;
    r.en = e; r.sync = sy; r.din = d;
    r.outs = o; r.v = v; r.s = s;
    r.fd = fd; r.err = er; r.lk = lk;
    return r;
  endfunction

  initial begin
    m_reset();
    tbl[0]  = mk(1, 0, 4'h1, 16'h0000, 4'h0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 4'h1, 16'h0000, 4'h0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 4'hF, 16'h0000, 4'h0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 4'h1, 16'h1000, 4'h1, 1, 0, 0, 1);
    tbl[4]  = mk(1, 0, 4'h0, 16'h1000, 4'h2, 2, 0, 0, 1);
    tbl[5]  = mk(1, 0, 4'h1, 16'h1010, 4'h4, 3, 0, 0, 1);
    tbl[6]  = mk(1, 0, 4'h0, 16'h1010, 4'h8, 0, 1, 0, 1);
    tbl[7]  = mk(1, 1, 4'h2, 16'h2010, 4'h1, 1, 0, 0, 1);
    tbl[8]  = mk(1, 0, 4'h3, 16'h2310, 4'h2, 2, 0, 0, 1);
    tbl[9]  = mk(1, 1, 4'h1, 16'h1310, 4'h1, 1, 0, 1, 1);
    tbl[10] = mk(1, 0, 4'h4, 16'h1410, 4'h2, 2, 0, 0, 1);
    tbl[11] = mk(0, 1, 4'h9, 16'h1410, 4'h0, 2, 0, 0, 1);
    for (int i = 12; i < 16; i++)
      tbl[i] = mk(0, 0, 4'hF, 16'h1410, 4'h0, 2, 0, 0, 1);
    tbl[16] = mk(1, 0, 4'h5, 16'h1450, 4'h4, 3, 0, 0, 1);
    tbl[17] = mk(1, 0, 4'h6, 16'h1456, 4'h8, 0, 1, 0, 1);
    tbl[18] = mk(1, 1, 4'h7, 16'h7456, 4'h1, 1, 0, 0, 1);

    // Reset held with activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'($urandom);
      sync = 1'($urandom);
      din = 4'($urandom);
      @(posedge clk);
      #1;
      check_all("rst");
    end
    @(negedge clk);
    en = 1'b0;
    sync = 1'b0;
    rst_n = 1'b1;
    tick(0, 0, 4'h0, "post_rst");

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].en, tbl[i].sync, tbl[i].din, "tbl");
      for (int c = 0; c < 4; c++)
        chk($sformatf("tbl%0d.out%0d", i, c),
            32'(o0[c]), 32'(tbl[i].outs[15-4*c -: 4]));
      chk($sformatf("tbl%0d.v", i), 32'(v0),
          32'(tbl[i].v));
      chk($sformatf("tbl%0d.s", i), 32'(s0),
          32'(tbl[i].s));
      chk($sformatf("tbl%0d.fd", i), 32'(fd0),
          32'(tbl[i].fd));
      chk($sformatf("tbl%0d.err", i), 32'(er0),
          32'(tbl[i].err));
      chk($sformatf("tbl%0d.lk", i), 32'(lk0),
          32'(tbl[i].lk));
    end

    // Latched frame: nothing moves until slot d.
    do_reset("rst2");
    tick(1, 1, 4'h3, "lf");
    tick(1, 0, 4'h5, "lf");
    tick(1, 0, 4'hA, "lf");
    for (int c = 0; c < 4; c++)
      chk("lf.hold", 32'(o1[c]), 32'h0);
    chk("lf.hold.v", 32'(v1), 32'h0);
    tick(1, 0, 4'hC, "lf");
    chk("lf.a", 32'(o1[0]), 32'h3);
    chk("lf.b", 32'(o1[1]), 32'h5);
    chk("lf.c", 32'(o1[2]), 32'hA);
    chk("lf.d", 32'(o1[3]), 32'hC);
    chk("lf.v", 32'(v1), 32'hF);
    chk("lf.fd", 32'(fd1), 32'h1);
    tick(0, 0, 4'h0, "lf");
    chk("lf.v_off", 32'(v1), 32'h0);
    chk("lf.d_hold", 32'(o1[3]), 32'hC);

    // Reset mid-frame, then relock needs a sync.
    tick(1, 1, 4'h7, "mid");
    tick(1, 0, 4'h8, "mid");
    do_reset("rst3");
    for (int c = 0; c < 4; c++)
      chk("mid.clr", 32'(o1[c]), 32'h0);
    tick(1, 0, 4'hF, "mid");
    chk("mid.lk", 32'(lk1), 32'h0);
    chk("mid.s", 32'(s0), 32'h0);

    // Random traffic, occasional misplaced syncs.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset("rst4");
      tick(1'(($urandom % 4) != 0),
           1'(($urandom % 7) == 0),
           4'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
